alu_result_checker: RTL and testbench
=====================================

# alu_result_checker

Hardware scoreboard on the result side of the `alu`. It taps the same `A`/`B`/`opcode` issue stream the ALU receives and computes the expected 8-bit result with an internal reference model. It delays that expectation by the ALU's pipeline latency and compares it against the ALU `result`, counting checks and mismatches. It lets the ALU be signed off on-chip or in a stimulus-only bench, without a software model.

## Interface
- `LATENCY`, default 2: cycles from the edge that samples `A`/`B`/`opcode` into the ALU to the edge at which `result` is valid to sample. Legal range is 1..8; 2 matches the registered-input/registered-output `alu`.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: `A`/`B`/`opcode` on this edge are being issued to the ALU.
- `A`, input, 4, signed: operand A, identical to the ALU input.
- `B`, input, 4, signed: operand B, identical to the ALU input.
- `opcode`, input, 4: operation select, identical to the ALU input.
- `result`, input, 8, signed: ALU output.
- `clr`, input, 1: synchronous clear of the counters and sticky flags only.
- `check_valid`, output, 1: one-cycle pulse; a comparison completed on this edge.
- `mismatch`, output, 1: qualified by `check_valid`; expected ≠ `result`.
- `expected`, output, 8: expected value for the current check.
- `chk_count`, output, 16: number of checks, saturating at 0xFFFF.
- `err_count`, output, 16: number of mismatches, saturating at 0xFFFF.
- `pass`, output, 1: `chk_count != 0 && err_count == 0`.
- `first_err`, output, 24: snapshot of the first mismatch, laid out as {opcode[23:20], A[19:16], B[15:12], expected[11:4], result_hi[3:0]}. Only populated when logging is enabled (see Configuration).

## Operation
Reference model: all arithmetic is in signed 8 bits, with `A`/`B` sign-extended. Logic ops zero-extend their 4-bit result.
- 0000: A+B
- 0001: A−B
- 0010: A×B
- 0011: −A
- 0100: A&B
- 0101: A|B
- 0110: A^B
- 0111: ~A (4-bit)
- 1000: A<<1
- 1001: A>>>1
- 1010: (A==B)
- 1011: (A<B) signed
- 1100: max(A,B)
- 1101: min(A,B)
- 1110: |A|
- 1111: A+1

Pipeline:
- Shift register of LATENCY stages, each holding {valid, expected[7:0], opcode, A, B}.
- The expected value is computed combinationally at issue, then registered.
- Stage LATENCY−1 valid on an edge → compare `result`, update outputs and counters on that edge.

Control FSM:
- IDLE (after reset or `clr`): `pass`=0.
- RUN: entered on the first `check_valid`.
- FAIL: entered on the first mismatch; sticky until `rst`/`clr`.
- `pass` is asserted only while in RUN.

Counters:
- `chk_count` increments on every check.
- `err_count` increments on every mismatch.
- Both saturate and do not wrap.

## Timing
- Reset values: `check_valid`=0, `mismatch`=0, `expected`=0x00, `chk_count`=0, `err_count`=0, `pass`=0, `first_err`=0. The FSM is in IDLE and all pipeline valids are 0.
- An issue sampled at edge k produces `check_valid`=1 after edge k+LATENCY, for exactly one cycle per issue.
- Back-to-back issues on consecutive edges give back-to-back checks; there are no stalls or bubbles.
- `rst` mid-operation: all in-flight entries are discarded and no check fires for them.
- `clr`:
  - Zeroes the counters and `first_err`, and returns the FSM to IDLE.
  - The pipeline is kept, so in-flight checks still complete after the clear.
  - If `clr` and a check occur on the same edge, `clr` wins and that check is not counted.
- Saturation: at 0xFFFF further events leave the count unchanged; the FSM still updates.

## Configuration
- `ALU_CHK_LOG_EN` defined:
  - The first mismatch after `rst`/`clr` latches `first_err`.
  - Later mismatches do not overwrite it.
  - Simulation additionally `$display`s every mismatch with time, opcode, A, B, expected and result.
- `ALU_CHK_LOG_EN` undefined:
  - `first_err` is tied to 0 and no capture registers or `$display` are built.
  - All other behaviour is identical.

## Test plan
- **Reset:** assert `rst` 3 cycles → every output is at its reset value and `check_valid` stays 0 for 10 idle cycles.
- **Opcode sweep:** golden ALU, A=4'b1110 (−2), B=4'b0110 (6), sweep opcode 0..15 back-to-back.
  - Spot checks: `expected` is 0x04 for op 0, 0xF8 for op 1, 0xF4 for op 2, 0x06 for op 4, 0x01 for op 11.
  - 16 `check_valid` pulses, each LATENCY=2 cycles after its issue.
  - End state: `chk_count`=16, `err_count`=0, `pass`=1.
- **Fault injection:** force `result`=0x00 for the op-0 check only.
  - `mismatch`=1 on that pulse.
  - `err_count`=1 and `pass`=0 for the rest of the sweep.
  - With `ALU_CHK_LOG_EN`: `first_err`={0000, 1110, 0110, 0x04, 0x0}.
- **`clr` collision:** pulse `clr` on the same edge as the 5th check → `chk_count`=0 after that edge, then counting resumes at 1 on the 6th check.
- **Reset mid-flight:** issue 2 ops, assert `rst` on the next edge → no `check_valid` ever fires for those ops.
- **Saturation:** preload via a bench `force` `chk_count`=0xFFFE, then 3 checks → count reads 0xFFFF and holds.

Source files
------------

// File: rtl/alu_result_checker.sv
// Result-side scoreboard for the alu: predicts each result, delays it by LATENCY and compares.
// Define ALU_CHK_LOG_EN to capture the first mismatch in first_err and log mismatches in simulation.
module alu_result_checker #(
    parameter int unsigned LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [3:0]  A,
    input  logic [3:0]  B,
    input  logic [3:0]  opcode,
    input  logic [7:0]  result,
    input  logic        clr,
    output logic        check_valid,
    output logic        mismatch,
    output logic [7:0]  expected,
    output logic [15:0] chk_count,
    output logic [15:0] err_count,
    output logic        pass,
    output logic [23:0] first_err
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FAIL = 2'd2;

    logic signed [7:0] a_s, b_s;
    logic        [7:0] ref_d;

    logic              vld_q [LATENCY];
    logic        [7:0] exp_q [LATENCY];

    logic              cv_q, mm_q;
    logic        [7:0] exo_q;
    logic       [15:0] chk_q, chk_d;
    logic       [15:0] err_q, err_d;
    logic        [1:0] state_q, state_d;
    logic              fire, diff;

    assign a_s = {{4{A[3]}}, A};
    assign b_s = {{4{B[3]}}, B};

    always_comb begin
        ref_d = '0;
        unique case (opcode)
            4'h0: ref_d = a_s + b_s;
            4'h1: ref_d = a_s - b_s;
            4'h2: ref_d = a_s * b_s;
            4'h3: ref_d = -a_s;
            4'h4: ref_d = {4'b0, A & B};
            4'h5: ref_d = {4'b0, A | B};
            4'h6: ref_d = {4'b0, A ^ B};
            4'h7: ref_d = {4'b0, ~A};
            4'h8: ref_d = a_s <<< 1;
            4'h9: ref_d = a_s >>> 1;
            4'hA: ref_d = {7'b0, a_s == b_s};
            4'hB: ref_d = {7'b0, a_s < b_s};
            4'hC: ref_d = (a_s > b_s) ? a_s : b_s;
            4'hD: ref_d = (a_s < b_s) ? a_s : b_s;
            4'hE: ref_d = a_s[7] ? -a_s : a_s;
            4'hF: ref_d = a_s + 8'sd1;
            default: ref_d = '0;
        endcase
    end

    // Only the valid bits are reset; payload follows its valid bit down the line.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < LATENCY; i++) vld_q[i] <= 1'b0;
        end else begin
            vld_q[0] <= in_valid;
            for (int unsigned i = 1; i < LATENCY; i++) vld_q[i] <= vld_q[i-1];
        end
    end

    always_ff @(posedge clk) begin
        exp_q[0] <= ref_d;
        for (int unsigned i = 1; i < LATENCY; i++) exp_q[i] <= exp_q[i-1];
    end

    assign fire = vld_q[LATENCY-1];
    assign diff = exp_q[LATENCY-1] != result;

    // clr overrides a coincident check: nothing is counted and the FSM goes to IDLE.
    always_comb begin
        chk_d   = chk_q;
        err_d   = err_q;
        state_d = state_q;
        if (clr) begin
            chk_d   = '0;
            err_d   = '0;
            state_d = ST_IDLE;
        end else if (fire) begin
            if (chk_q != '1) chk_d = chk_q + 16'd1;
            if (diff) begin
                if (err_q != '1) err_d = err_q + 16'd1;
                state_d = ST_FAIL;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cv_q    <= 1'b0;
            mm_q    <= 1'b0;
            exo_q   <= '0;
            chk_q   <= '0;
            err_q   <= '0;
            state_q <= ST_IDLE;
        end else begin
            cv_q    <= fire;
            mm_q    <= fire && diff;
            if (fire) exo_q <= exp_q[LATENCY-1];
            chk_q   <= chk_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

`ifdef ALU_CHK_LOG_EN
    logic [11:0] tag_q [LATENCY];
    logic [23:0] first_q, first_d;

    always_ff @(posedge clk) begin
        tag_q[0] <= {opcode, A, B};
        for (int unsigned i = 1; i < LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end

    // FAIL state doubles as "a mismatch has already been captured since rst/clr".
    always_comb begin
        first_d = first_q;
        if (clr) begin
            first_d = '0;
        end else if (fire && diff && state_q != ST_FAIL) begin
            first_d = {tag_q[LATENCY-1], exp_q[LATENCY-1], result[7:4]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) first_q <= '0;
        else     first_q <= first_d;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && fire && diff) begin
            $display("alu_result_checker: mismatch t=%0t op=%h A=%h B=%h expected=%h result=%h",
                     $time, tag_q[LATENCY-1][11:8], tag_q[LATENCY-1][7:4],
                     tag_q[LATENCY-1][3:0], exp_q[LATENCY-1], result);
        end
    end
`endif

    assign first_err = first_q;
`else
    assign first_err = '0;
`endif

    assign check_valid = cv_q;
    assign mismatch    = mm_q;
    assign expected    = exo_q;
    assign chk_count   = chk_q;
    assign err_count   = err_q;
    assign pass        = (state_q == ST_RUN);

endmodule

// File: tb/tb_alu_result_checker.sv
// Self-checking bench for alu_result_checker: golden ALU stand-in, vector table and randomized model checks.
`timescale 1ns/1ps
module tb_alu_result_checker;

    localparam int unsigned L = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  A = '0, B = '0, opcode = '0;
    logic [7:0]  result = '0;
    logic        clr = 1'b0;
    logic        check_valid, mismatch, pass;
    logic [7:0]  expected;
    logic [15:0] chk_count, err_count;
    logic [23:0] first_err;

    always #5 clk = ~clk;

    alu_result_checker #(.LATENCY(L)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B), .opcode(opcode),
        .result(result), .clr(clr), .check_valid(check_valid), .mismatch(mismatch),
        .expected(expected), .chk_count(chk_count), .err_count(err_count),
        .pass(pass), .first_err(first_err)
    );

    typedef struct { logic [3:0] op; logic [3:0] a; logic [3:0] b; logic [7:0] exp; } vec_t;
    typedef struct { int due; logic [7:0] exp; logic [7:0] res; logic [11:0] tag; } pend_t;

    vec_t        vecs [16];
    pend_t       pend [$];
    logic [7:0]  res_at [int];
    int          edge_n = 0;
    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_chk = '0, m_err = '0;
    logic [23:0] m_first = '0;
    logic        m_cv = 1'b0, m_mm = 1'b0;
    logic [7:0]  m_exp = '0;
    int          cv_edges [$];
    logic [7:0]  cv_vals [$];
    logic        cv_mm [$];

    // Spec rules in plain integer arithmetic, reduced to 8 bits at the end.
    function automatic logic [7:0] ref_alu(input logic [3:0] op, input logic [3:0] a4, input logic [3:0] b4);
        int a, b, r;
        a = (a4 >= 4'd8) ? int'(a4) - 16 : int'(a4);
        b = (b4 >= 4'd8) ? int'(b4) - 16 : int'(b4);
        case (op)
            4'h0: r = a + b;
            4'h1: r = a - b;
            4'h2: r = a * b;
            4'h3: r = -a;
            4'h4: r = int'(a4 & b4);
            4'h5: r = int'(a4 | b4);
            4'h6: r = int'(a4 ^ b4);
            4'h7: r = 15 - int'(a4);
            4'h8: r = a * 2;
            4'h9: r = (a < 0) ? (a - 1) / 2 : a / 2;
            4'hA: r = (a == b) ? 1 : 0;
            4'hB: r = (a < b) ? 1 : 0;
            4'hC: r = (a > b) ? a : b;
            4'hD: r = (a < b) ? a : b;
            4'hE: r = (a < 0) ? -a : a;
            default: r = a + 1;
        endcase
        return r[7:0];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (edge %0d)", name, act, req, edge_n);
        end
    endtask

    task automatic tick(input logic v, input logic [3:0] a, input logic [3:0] b, input logic [3:0] op,
                        input logic c, input logic r, input logic bad);
        logic [7:0] g, rv;
        logic       fire;
        pend_t      p;
        in_valid = v; A = a; B = b; opcode = op; clr = c; rst = r;
        result = res_at.exists(edge_n) ? res_at[edge_n] : 8'h00;
        g  = ref_alu(op, a, b);
        rv = bad ? ((g == 8'h00) ? 8'hFF : 8'h00) : g;
        if (v) res_at[edge_n + int'(L)] = rv;
        @(posedge clk);
        #1;
        if (r) begin
            pend.delete();
            m_chk = '0; m_err = '0; m_first = '0; m_cv = 1'b0; m_mm = 1'b0; m_exp = '0;
        end else begin
            fire = (pend.size() > 0) && (pend[0].due == edge_n);
            m_cv = fire;
            m_mm = 1'b0;
            if (fire) begin
                p = pend.pop_front();
                m_exp = p.exp;
                m_mm  = (p.res != p.exp);
            end
            if (c) begin
                m_chk = '0; m_err = '0; m_first = '0;
            end else if (fire) begin
                if (m_chk != 16'hFFFF) m_chk = m_chk + 16'd1;
                if (m_mm) begin
                    if (m_err == 16'd0) m_first = {p.tag, p.exp, p.res[7:4]};
                    if (m_err != 16'hFFFF) m_err = m_err + 16'd1;
                end
            end
            if (v) pend.push_back('{due: edge_n + int'(L), exp: g, res: rv, tag: {op, a, b}});
        end
        check("check_valid", 32'(check_valid), 32'(m_cv));
        check("mismatch", 32'(mismatch), 32'(m_mm));
        if (m_cv || r) check("expected", 32'(expected), 32'(m_exp));
        check("chk_count", 32'(chk_count), 32'(m_chk));
        check("err_count", 32'(err_count), 32'(m_err));
        check("pass", 32'(pass), 32'(m_chk != 16'd0 && m_err == 16'd0));
`ifdef ALU_CHK_LOG_EN
        check("first_err", 32'(first_err), 32'(m_first));
`else
        check("first_err", 32'(first_err), 32'h0);
`endif
        if (check_valid) begin
            cv_edges.push_back(edge_n);
            cv_vals.push_back(expected);
            cv_mm.push_back(mismatch);
        end
        edge_n++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sweep(input logic fault_op0, output int first_issue);
        cv_edges.delete(); cv_vals.delete(); cv_mm.delete();
        first_issue = edge_n;
        for (int i = 0; i < 16; i++)
            tick(1'b1, vecs[i].a, vecs[i].b, vecs[i].op, 1'b0, 1'b0, fault_op0 && (i == 0));
        idle(int'(L) + 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fi, idle_cv;
        logic [7:0] tbl [16];
        tbl = '{8'h04, 8'hF8, 8'hF4, 8'h02, 8'h06, 8'h0E, 8'h08, 8'h01,
                8'hFC, 8'hFF, 8'h00, 8'h01, 8'h06, 8'hFE, 8'h02, 8'hFF};
        for (int i = 0; i < 16; i++) vecs[i] = '{op: 4'(i), a: 4'b1110, b: 4'b0110, exp: tbl[i]};

        // Reset, then quiet period.
        for (int i = 0; i < 3; i++) tick(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        idle_cv = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            if (check_valid) idle_cv++;
        end
        check("reset_idle_no_check", 32'(idle_cv), 32'h0);

        // Clean opcode sweep against the hand-computed table.
        sweep(1'b0, fi);
        check("sweep_pulses", 32'(cv_edges.size()), 32'd16);
        for (int i = 0; i < cv_edges.size() && i < 16; i++) begin
            check("sweep_expected", 32'(cv_vals[i]), 32'(vecs[i].exp));
            check("sweep_latency", 32'(cv_edges[i]), 32'(fi + i + int'(L)));
        end
        check("sweep_chk_end", 32'(chk_count), 32'd16);
        check("sweep_err_end", 32'(err_count), 32'd0);
        check("sweep_pass_end", 32'(pass), 32'd1);

        // Fault on the op-0 result.
        tick(1'b0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0);
        sweep(1'b1, fi);
        check("fault_pulses", 32'(cv_mm.size()), 32'd16);
        if (cv_mm.size() > 0) check("fault_mismatch_op0", 32'(cv_mm[0]), 32'd1);
        check("fault_err_count", 32'(err_count), 32'd1);
        check("fault_pass", 32'(pass), 32'd0);
`ifdef ALU_CHK_LOG_EN
        check("fault_first_err", 32'(first_err), 32'h0E6040);
`else
        check("fault_first_err", 32'(first_err), 32'h0);
`endif

        // clr on the same edge as the 5th check.
        tick(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), i == 6, 1'b0, 1'b0);
            if (i == 5) check("clr_before", 32'(chk_count), 32'd4);
            if (i == 6) check("clr_collision", 32'(chk_count), 32'd0);
            if (i == 7) check("clr_resume", 32'(chk_count), 32'd1);
        end
        idle(int'(L) + 1);

        // Reset with two ops in flight.
        tick(1'b1, 4'h3, 4'h5, 4'h0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'h7, 4'h1, 4'h2, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        idle_cv = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            if (check_valid) idle_cv++;
        end
        check("rst_midflight_no_check", 32'(idle_cv), 32'h0);

        // Saturation of chk_count from a preloaded value.
        tick(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        tick(1'b1, 4'h1, 4'h2, 4'h0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 4'h4, 4'h2, 4'h5, 1'b0, 1'b0, 1'b0);
        idle(int'(L) + 1);
        force dut.chk_q = 16'hFFFE;
        #1;
        release dut.chk_q;
        m_chk = 16'hFFFE;
        for (int i = 0; i < 3; i++) tick(1'b1, 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0, 1'b0);
        idle(int'(L) + 1);
        check("sat_chk_count", 32'(chk_count), 32'hFFFF);
        check("sat_pass", 32'(pass), 32'd1);

        // Randomized traffic with sporadic faults, clears and resets.
        tick(1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 4'($urandom),
                 $urandom_range(0, 31) == 0, $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0);
        idle(int'(L) + 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
